// File: rtl/mc_datapath_regs_pkg.sv
// Shared constants for the multicycle datapath register block: opcodes,
// load/store size encodings, result-select encodings and the reset NOP.
package mc_datapath_regs_pkg;

    // Base opcodes (Instr[6:0])
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpReg    = 7'h33;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJal    = 7'h6f;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;

    // funct3 load/store size encodings
    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    // Result multiplexer select
    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResLoad      = 2'b01,
        ResAluResult = 2'b10,
        ResAluOutAlt = 2'b11
    } result_src_e;

    // addi x0, x0, 0
    localparam logic [31:0] InstrNop = 32'h0000_0013;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: extracts sized load data from the raw memory word and
// places store data on the byte lanes addressed by the low address bits.
module mem_lane_align
    import mc_datapath_regs_pkg::*;
(
    input  logic [31:0] load_word_i,
    input  logic [1:0]  load_off_i,
    input  logic [2:0]  load_size_i,
    output logic [31:0] load_data_o,
    input  logic [31:0] store_word_i,
    input  logic [1:0]  store_off_i,
    input  logic [2:0]  store_size_i,
    input  logic        store_shift_i,
    output logic [31:0] store_data_o,
    output logic [3:0]  byte_en_o
);

    logic [31:0] load_shifted;

    // Load extraction: bring the addressed byte/half down to bit 0, then extend
    always_comb begin
        load_shifted = load_word_i >> {load_off_i, 3'b000};
        case (load_size_i)
            F3Byte:  load_data_o = {{24{load_shifted[7]}}, load_shifted[7:0]};
            F3Half:  load_data_o = {{16{load_shifted[15]}}, load_shifted[15:0]};
            F3ByteU: load_data_o = {24'h00_0000, load_shifted[7:0]};
            F3HalfU: load_data_o = {16'h0000, load_shifted[15:0]};
            default: load_data_o = load_word_i;
        endcase
    end

    // Store lane generation: shift data only during an actual store access
    always_comb begin
        store_data_o = store_shift_i ? (store_word_i << {store_off_i, 3'b000}) : store_word_i;
        case (store_size_i)
            F3Byte:  byte_en_o = 4'b0001 << store_off_i;
            F3Half:  byte_en_o = 4'b0011 << store_off_i;
            F3Word:  byte_en_o = 4'b1111;
            default: byte_en_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mc_datapath_regs.sv
// Non-architectural and architectural registers of a multicycle RV32 datapath:
// PC/OldPC/IR, operand latches, result mux, address mux, access alignment,
// sticky misalignment flag and a fetched-instruction counter.
module mc_datapath_regs
    import mc_datapath_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCUpdate,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        IRWrite,
    input  logic        AdrSrc,
    input  logic        MemWrite,
    input  logic [1:0]  ResultSrc,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    output logic [31:0] PC,
    output logic [31:0] OldPC,
    output logic [31:0] Instr,
    output logic [31:0] A,
    output logic [31:0] WriteData,
    output logic [31:0] ALUOut,
    output logic [31:0] Result,
    output logic [31:0] Adr,
    output logic [6:0]  Op,
    output logic [2:0]  funct3,
    output logic [3:0]  ByteEn,
    output logic        MemWriteOut,
    output logic        MisalignFault,
    output logic [31:0] RetireCnt
);

    logic [31:0] pc_q, pc_d, old_pc_q, old_pc_d, instr_q, instr_d, retire_q, retire_d;
    logic [31:0] a_q, wd_q, alu_out_q, data_q;
    logic [1:0]  off_q;
    logic [2:0]  sz_q;
    logic        fault_q;
    logic        pc_write, is_half, is_word, misaligned;
    logic [31:0] load_data;

    assign PC            = pc_q;
    assign OldPC         = old_pc_q;
    assign Instr         = instr_q;
    assign A             = a_q;
    assign ALUOut        = alu_out_q;
    assign RetireCnt     = retire_q;
    assign MisalignFault = fault_q;
    assign Op            = instr_q[6:0];
    assign funct3        = instr_q[14:12];

    assign pc_write = PCUpdate | (Branch & Zero);

    // Result multiplexer
    always_comb begin
        case (ResultSrc)
            ResLoad:      Result = load_data;
            ResAluResult: Result = ALUResult;
            default:      Result = alu_out_q;
        endcase
    end

    assign Adr = AdrSrc ? Result : pc_q;

    // Alignment is only meaningful on data accesses, never on instruction fetch
    always_comb begin
        is_half     = (funct3 == F3Half) || (funct3 == F3HalfU);
        is_word     = (funct3 == F3Word);
        misaligned  = AdrSrc & ((is_half & Adr[0]) | (is_word & (Adr[1:0] != 2'b00)));
        MemWriteOut = MemWrite & ~misaligned;
    end

    mem_lane_align u_lane (
        .load_word_i   (data_q),
        .load_off_i    (off_q),
        .load_size_i   (sz_q),
        .load_data_o   (load_data),
        .store_word_i  (wd_q),
        .store_off_i   (Adr[1:0]),
        .store_size_i  (funct3),
        .store_shift_i (AdrSrc & MemWrite),
        .store_data_o  (WriteData),
        .byte_en_o     (ByteEn)
    );

    // Next state for PC, IR and retire counter; OldPC takes the pre-update PC
    always_comb begin
        pc_d     = pc_q;
        old_pc_d = old_pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        if (pc_write) begin
            pc_d = Result;
        end
        if (IRWrite) begin
            old_pc_d = pc_q;
            instr_d  = ReadData;
            retire_d = retire_q + 32'd1;
        end
    end

    // Architectural state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            old_pc_q <= RESET_PC;
            instr_q  <= InstrNop;
            retire_q <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            old_pc_q <= old_pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end

    // Operand and data latches, loaded unconditionally every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= 32'd0;
            wd_q      <= 32'd0;
            alu_out_q <= 32'd0;
            data_q    <= 32'd0;
        end else begin
            a_q       <= RD1;
            wd_q      <= RD2;
            alu_out_q <= ALUResult;
            data_q    <= ReadData;
        end
    end

    // Remember access offset/size for the following load-writeback cycle; sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q   <= 2'b00;
            sz_q    <= F3Word;
            fault_q <= 1'b0;
        end else begin
            if (AdrSrc) begin
                off_q <= Adr[1:0];
                sz_q  <= funct3;
            end
            if (misaligned) begin
                fault_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Bench for mc_datapath_regs: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mc_datapath_regs;

    localparam logic [31:0] ResetPc = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCUpdate, Branch, Zero, IRWrite, AdrSrc, MemWrite;
    logic [1:0]  ResultSrc;
    logic [31:0] ALUResult, ReadData, RD1, RD2;
    logic [31:0] PC, OldPC, Instr, A, WriteData, ALUOut, Result, Adr, RetireCnt;
    logic [6:0]  Op;
    logic [2:0]  funct3;
    logic [3:0]  ByteEn;
    logic        MemWriteOut, MisalignFault;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic        chk_en  = 1'b0;

    always #5 clk = ~clk;

    mc_datapath_regs #(.RESET_PC(ResetPc)) dut (
        .clk(clk), .rst(rst), .PCUpdate(PCUpdate), .Branch(Branch), .Zero(Zero),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .ALUResult(ALUResult), .ReadData(ReadData), .RD1(RD1), .RD2(RD2),
        .PC(PC), .OldPC(OldPC), .Instr(Instr), .A(A), .WriteData(WriteData),
        .ALUOut(ALUOut), .Result(Result), .Adr(Adr), .Op(Op), .funct3(funct3),
        .ByteEn(ByteEn), .MemWriteOut(MemWriteOut), .MisalignFault(MisalignFault),
        .RetireCnt(RetireCnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_old, m_instr, m_a, m_wd, m_aluout, m_data, m_cnt;
    logic [1:0]  m_off;
    logic [2:0]  m_sz;
    logic        m_fault;

    function automatic logic [31:0] m_load();
        logic [31:0] w;
        w = m_data >> (8 * m_off);
        case (m_sz)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd4:    return w & 32'h0000_00FF;
            3'd5:    return w & 32'h0000_FFFF;
            default: return m_data;
        endcase
    endfunction

    function automatic logic [31:0] m_result();
        if (ResultSrc == 2'd1) return m_load();
        if (ResultSrc == 2'd2) return ALUResult;
        return m_aluout;
    endfunction

    function automatic logic [31:0] m_adr();
        return AdrSrc ? m_result() : m_pc;
    endfunction

    function automatic int m_lane();
        return int'(m_adr() % 4);
    endfunction

    function automatic logic [3:0] m_byteen();
        int f3 = int'(m_instr[14:12]);
        if (f3 == 0) return 4'(1 << m_lane());
        if (f3 == 1) return 4'(3 << m_lane());
        if (f3 == 2) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic m_mis();
        int f3 = int'(m_instr[14:12]);
        if (!AdrSrc) return 1'b0;
        if ((f3 == 1 || f3 == 5) && (m_adr() % 2 != 0)) return 1'b1;
        if (f3 == 2 && m_lane() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_wdata();
        return (AdrSrc && MemWrite) ? (m_wd << (8 * m_lane())) : m_wd;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= ResetPc; m_old <= ResetPc; m_instr <= 32'h13; m_cnt <= 0;
            m_a <= 0; m_wd <= 0; m_aluout <= 0; m_data <= 0;
            m_off <= 0; m_sz <= 3'd2; m_fault <= 1'b0;
        end else begin
            if (PCUpdate || (Branch && Zero)) m_pc <= m_result();
            if (IRWrite) begin
                m_old <= m_pc; m_instr <= ReadData; m_cnt <= m_cnt + 1;
            end
            m_a <= RD1; m_wd <= RD2; m_aluout <= ALUResult; m_data <= ReadData;
            if (AdrSrc) begin
                m_off <= 2'(m_lane());
                m_sz  <= m_instr[14:12];
            end
            if (m_mis()) m_fault <= 1'b1;
        end
    end

    // Compare every output against the model away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", PC, m_pc);
            check("oldpc", OldPC, m_old);
            check("instr", Instr, m_instr);
            check("op", 32'(Op), m_instr & 32'h7F);
            check("funct3", 32'(funct3), (m_instr >> 12) & 32'h7);
            check("a", A, m_a);
            check("aluout", ALUOut, m_aluout);
            check("retire", RetireCnt, m_cnt);
            check("result", Result, m_result());
            check("adr", Adr, m_adr());
            check("writedata", WriteData, m_wdata());
            check("byteen", 32'(ByteEn), 32'(m_byteen()));
            check("memwrite_out", 32'(MemWriteOut), 32'(MemWrite && !m_mis()));
            check("fault", 32'(MisalignFault), 32'(m_fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        PCUpdate = 0; Branch = 0; Zero = 0; IRWrite = 0; AdrSrc = 0; MemWrite = 0;
        ResultSrc = 2'd0; ALUResult = 0; ReadData = 0; RD1 = 0; RD2 = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_pc", PC, 32'h100);
        check("rst_instr", Instr, 32'h13);
        check("rst_cnt", RetireCnt, 32'h0);
        check("rst_fault", 32'(MisalignFault), 32'h0);
        chk_en = 1'b1;

        // Fetch
        rst = 0; IRWrite = 1; PCUpdate = 1; ResultSrc = 2'b10;
        ALUResult = 32'h104; ReadData = 32'h0050_0093;
        tick();
        check("fetch_pc", PC, 32'h104);
        check("fetch_oldpc", OldPC, 32'h100);
        check("fetch_instr", Instr, 32'h0050_0093);
        check("fetch_op", 32'(Op), 32'h13);
        check("fetch_cnt", RetireCnt, 32'h1);

        // Branch not taken, then taken to ALUOut
        IRWrite = 0; PCUpdate = 0; Branch = 1; Zero = 0; ResultSrc = 2'b00; ALUResult = 32'h80;
        tick();
        check("br_nt_pc", PC, 32'h104);
        check("br_aluout", ALUOut, 32'h80);
        Zero = 1;
        tick();
        check("br_t_pc", PC, 32'h80);

        // lb from 0x203
        Branch = 0; Zero = 0; IRWrite = 1; ReadData = 32'h0000_0003;
        tick();
        IRWrite = 0; AdrSrc = 1; ResultSrc = 2'b10; ALUResult = 32'h203; ReadData = 32'h80FF_1234;
        #1 check("lb_adr", Adr, 32'h203);
        tick();
        AdrSrc = 0; ResultSrc = 2'b01;
        #1 check("lb_result", Result, 32'hFFFF_FF80);

        // lbu from 0x203
        IRWrite = 1; ReadData = 32'h0000_4003; ResultSrc = 2'b00;
        tick();
        IRWrite = 0; AdrSrc = 1; ResultSrc = 2'b10; ALUResult = 32'h203; ReadData = 32'h80FF_1234;
        tick();
        AdrSrc = 0; ResultSrc = 2'b01;
        #1 check("lbu_result", Result, 32'h0000_0080);

        // sh to 0x202
        IRWrite = 1; ReadData = 32'h0000_1023; ResultSrc = 2'b00; RD2 = 32'h0000_ABCD;
        tick();
        IRWrite = 0; AdrSrc = 1; ResultSrc = 2'b10; ALUResult = 32'h202; MemWrite = 1;
        #1;
        check("sh_byteen", 32'(ByteEn), 32'hC);
        check("sh_wdata", WriteData, 32'hABCD_0000);
        check("sh_mwo", 32'(MemWriteOut), 32'h1);

        // sw to 0x201: suppressed and sticky fault
        IRWrite = 1; ReadData = 32'h0000_2023; AdrSrc = 0; MemWrite = 0; ResultSrc = 2'b00;
        tick();
        IRWrite = 0; AdrSrc = 1; ResultSrc = 2'b10; ALUResult = 32'h201; MemWrite = 1;
        #1;
        check("sw_mwo", 32'(MemWriteOut), 32'h0);
        check("sw_fault_pre", 32'(MisalignFault), 32'h0);
        tick();
        AdrSrc = 0; MemWrite = 0;
        check("sw_fault_set", 32'(MisalignFault), 32'h1);
        repeat (10) tick();
        check("sw_fault_hold", 32'(MisalignFault), 32'h1);

        // Asynchronous reset mid-cycle
        #2 rst = 1;
        #1;
        check("arst_pc", PC, ResetPc);
        check("arst_cnt", RetireCnt, 32'h0);
        check("arst_fault", 32'(MisalignFault), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst       = 0;
            PCUpdate  = 1'($urandom_range(0, 1));
            Branch    = 1'($urandom_range(0, 1));
            Zero      = 1'($urandom_range(0, 1));
            IRWrite   = 1'($urandom_range(0, 1));
            AdrSrc    = ($urandom_range(0, 2) == 0);
            MemWrite  = 1'($urandom_range(0, 1));
            ResultSrc = 2'($urandom_range(0, 3));
            ALUResult = $urandom;
            if ($urandom_range(0, 1) == 1) ALUResult[1:0] = 2'b00;
            ReadData  = $urandom;
            RD1       = $urandom;
            RD2       = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1;
                #1 check("rnd_arst_pc", PC, ResetPc);
            end
        end

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
